// File: rtl/mdu_issue_arbiter.sv
// mdu_issue_arbiter
// Arbitrates two requesters onto a single multiply/divide unit (MDU) that
// shares the HILO register. The unit is owned by one operation at a time,
// from acceptance to completion or flush.
//
// Handshakes:
//   requester side: a request transfers in a cycle where reqX_valid and
//   reqX_ready are both high. A requester may drop valid at any time before
//   it is accepted. Ready can be high while valid is low.
//   MDU side: mdu_req holds, with mdu_operator/mdu_oprand stable, until the
//   MDU returns mdu_oprand_ok. mdu_data_ok marks the result. It can arrive in
//   the same cycle as mdu_oprand_ok or in any later cycle.
//
// state_dbg exposes the FSM state (00 IDLE, 01 ISSUE, 10 WAIT).
module mdu_issue_arbiter #(
   parameter int OPW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   input  logic           req1_valid,
   input  logic [OPW-1:0] req0_op,
   input  logic [OPW-1:0] req1_op,
   input  logic [63:0]    req0_oprand,
   input  logic [63:0]    req1_oprand,
   output logic           req0_ready,
   output logic           req1_ready,
   input  logic           flush,
   output logic           mdu_req,
   output logic [OPW-1:0] mdu_operator,
   output logic [63:0]    mdu_oprand,
   input  logic           mdu_oprand_ok,
   input  logic           mdu_data_ok,
   output logic           mdu_cancel,
   output logic           resp_valid,
   output logic           resp_src,
   output logic           busy,
   output logic [1:0]     state_dbg
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_ISSUE = 2'b01;
   localparam logic [1:0] S_WAIT  = 2'b10;

   logic [1:0]     state_q;
   logic [1:0]     state_d;
   // rr_pref_q names the requester that wins when both are valid.
   // It is reset to req0, and after each acceptance it points away from the
   // id just accepted.
   logic           rr_pref_q;
   logic [OPW-1:0] op_q;
   logic [63:0]    oprand_q;
   logic           src_q;

   logic           is_idle;
   logic           grant;
   logic           accept;
   logic           complete;

   assign is_idle = (state_q == S_IDLE);

   // Pick the requester to offer ready to: the lone valid one, or the preferred one on a tie
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = rr_pref_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end else begin
         grant = rr_pref_q & ~req0_valid;
      end
   end

   assign req0_ready = is_idle && !flush && (grant == 1'b0);
   assign req1_ready = is_idle && !flush && (grant == 1'b1);
   assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

   // A completion only counts while the unit is owned and not being flushed.
   // mdu_data_ok in IDLE is stray and is ignored.
   assign complete = !flush &&
                     (((state_q == S_ISSUE) && mdu_oprand_ok && mdu_data_ok) ||
                      ((state_q == S_WAIT) && mdu_data_ok));

   // Next-state selection for the IDLE -> ISSUE -> WAIT ownership cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (mdu_oprand_ok && mdu_data_ok) begin
               state_d = S_IDLE;
            end else if (mdu_oprand_ok) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush || mdu_data_ok) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the accepted request and steer the round-robin preference away from it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_pref_q <= 1'b0;
         op_q      <= '0;
         oprand_q  <= '0;
         src_q     <= 1'b0;
      end else if (accept) begin
         rr_pref_q <= ~grant;
         src_q     <= grant;
         op_q      <= grant ? req1_op : req0_op;
         oprand_q  <= grant ? req1_oprand : req0_oprand;
      end
   end

   assign mdu_req      = (state_q == S_ISSUE) && !flush;
   assign mdu_cancel   = !is_idle && flush;
   assign mdu_operator = op_q;
   assign mdu_oprand   = oprand_q;
   assign resp_valid   = complete;
   assign resp_src     = src_q;
   assign busy         = !is_idle;
   assign state_dbg    = state_q;

endmodule
